shl_seq: RTL
============

SHL_SEQ -- requirements
Module: shl_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; power of two, at least 2.
REQ-002 SHALL have derived parameter SHAMT_W, default $clog2(DATA_W) (5), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port in_data  input  DATA_W  operand to shift left.
REQ-008 SHALL have port in_shamt  input  SHAMT_W  left-shift amount.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_data  output  DATA_W  shifted result.
REQ-012 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-013 SHALL compute out_data = in_data << in_shamt (logical left shift), zero-filling from the LSB, with bits shifted past the MSB discarded.
REQ-014 SHALL implement the states IDLE, SHIFT and DONE.
REQ-015 SHALL assert in_ready only in IDLE; a request is accepted when in_valid && in_ready at a rising edge.
REQ-016 On acceptance SHALL capture in_data into the working register and in_shamt into the amount register, set the stage index to SHAMT_W-1, and enter SHIFT.
REQ-017 In SHIFT, each cycle SHALL shift the working register left by 2^stage if amount[stage] is 1, otherwise hold it, then decrement the stage index.
REQ-018 After processing stage 0, SHALL enter DONE with out_valid=1, giving a fixed latency of SHAMT_W cycles (5 at default) from the acceptance edge to out_valid.
REQ-019 In DONE SHALL hold out_valid=1 and out_data stable until out_ready=1, then return to IDLE at that edge.
REQ-020 SHALL ignore in_valid while not in IDLE; no request is queued, dropped or corrupted.
REQ-021 SHALL NOT assert in_ready in the same cycle as out_valid (no overlap of requests); the next acceptance is possible one cycle after the DONE->IDLE transition.
REQ-022 SHALL treat in_shamt=0 as a legal request, returning in_data unchanged after normal latency.
REQ-023 SHALL keep out_data equal to the last result while in IDLE (value 0 before the first result).

Reset
REQ-024 While rst=1 at an edge SHALL go to IDLE, with in_ready=1, out_valid=0, busy=0, out_data=0, and all working, amount and stage registers cleared.
REQ-025 Reset asserted mid-operation (SHIFT or DONE) SHALL abort the operation; no out_valid pulse follows reset release.

Configuration
REQ-026 Macro SHL_SEQ_EARLY_EXIT_EN: when defined, after processing stage s in SHIFT, SHALL enter DONE if amount[s-1:0]==0 (always for s=0), so latency equals (SHAMT_W - index of lowest set bit) cycles, and 1 cycle for shamt=0.
REQ-027 When SHL_SEQ_EARLY_EXIT_EN is undefined, SHALL use the fixed latency of REQ-018; results are identical in both builds.

Structure
REQ-028 Package shl_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and the default DATA_W constant.
REQ-029 SHALL instantiate one sub-module, shl_stage: combinational, shifting by 2^stage when enable is set, with the stage index as input.

Verification
REQ-030 Accept 0x0000_0001 with shamt 31 -> out_data 0x8000_0000, with out_valid rising 5 cycles after acceptance (early exit undefined).
REQ-031 Accept 0xFFFF_FFFF with shamt 16 -> 0xFFFF_0000; latency 5 without early exit, 1 with SHL_SEQ_EARLY_EXIT_EN.
REQ-032 Accept 0x1234_5678 with shamt 0 -> 0x1234_5678; with early exit, latency 1.
REQ-033 Accept 0x8000_0001 with shamt 4 and hold out_ready=0 for 3 cycles after out_valid -> out_data stays 0x0000_0010 and out_valid stays 1; in_ready returns to 1 the cycle after out_ready.
REQ-034 Drive in_valid with 0xDEAD_BEEF while busy -> not accepted; the in-flight result is unaffected.
REQ-035 Assert rst for 1 cycle during SHIFT -> next cycle in IDLE, out_valid=0, out_data=0, in_ready=1; no stray result follows.

Source files
------------

// File: rtl/shl_pkg.sv
// ============================================================================
// Module      : shl_pkg
// Description : Shared types and constants for the sequential left shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shl_pkg;

    localparam int c_data_w_default = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shl_stage.sv
// ============================================================================
// Module      : shl_stage
// Description : Combinational stage; shifts left by 2^stage when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shl_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_stage,
    input  logic               i_en,
    output logic [DATA_W-1:0]  o_data
);

    // 2^(SHAMT_W-1) always fits in SHAMT_W bits, so no wider distance is needed
    logic [SHAMT_W-1:0] w_dist;

    assign w_dist = SHAMT_W'(1) << i_stage;
    assign o_data = i_en ? (i_data << w_dist) : i_data;

endmodule

`default_nettype wire

// File: rtl/shl_seq.sv
// ============================================================================
// Module      : shl_seq
// Description : Sequential logical left shifter, one binary stage per cycle.
//               Optional macro SHL_SEQ_EARLY_EXIT_EN finishes once no lower
//               amount bits remain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shl_seq
    import shl_pkg::*;
#(
    parameter int DATA_W  = c_data_w_default,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_work;
    logic [SHAMT_W-1:0] r_amt;
    logic [SHAMT_W-1:0] r_stage;
    logic [DATA_W-1:0]  w_shifted;
    logic               w_last;
    logic               w_accept;

    shl_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .i_data  (r_work),
        .i_stage (r_stage),
        .i_en    (r_amt[r_stage]),
        .o_data  (w_shifted)
    );

`ifdef SHL_SEQ_EARLY_EXIT_EN
    // Remaining stages are no-ops once every lower amount bit is clear
    logic [SHAMT_W-1:0] w_low_mask;
    assign w_low_mask = (SHAMT_W'(1) << r_stage) - SHAMT_W'(1);
    assign w_last     = ((r_amt & w_low_mask) == '0);
`else
    assign w_last     = (r_stage == '0);
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign w_accept  = in_valid && in_ready;
    // The work register only changes after acceptance, so it holds the last
    // result throughout IDLE and DONE
    assign out_data  = r_work;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work  <= '0;
            r_amt   <= '0;
            r_stage <= '0;
        end else if (w_accept) begin
            r_work  <= in_data;
            r_amt   <= in_shamt;
            r_stage <= SHAMT_W'(SHAMT_W - 1);
        end else if (r_state == SHIFT) begin
            r_work  <= w_shifted;
            r_stage <= r_stage - SHAMT_W'(1);
        end
    end

endmodule

`default_nettype wire
